// File: rtl/usb_cfg_pkg.sv
// rtl/usb_cfg_pkg.sv - shared types and constants for the USB bitstream word assembler
//
// Purpose: holds the assembler state enum, the default sync/desync words,
// the word geometry and a byte-lane packing helper.
// Ports: none (package).
// Optional feature macro used by the assembler: USB_ASSEMBLER_TIMEOUT_EN.

package usb_cfg_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_SYNCED = 1'b1
  } asm_state_e;

  localparam logic [31:0] SYNC_WORD_DEFAULT   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD_DEFAULT = 32'h0000_0008;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Writes byte b into lane (3 - idx) of word, so byte 0 of a word lands
  // in bits [31:24] (MSB first).
  function automatic logic [31:0] put_byte_msb_first(
    input logic [31:0]           word,
    input logic [BYTE_IDX_W-1:0] idx,
    input logic [7:0]            b
  );
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/usb_cfg_idle_timer.sv
// rtl/usb_cfg_idle_timer.sv - idle-cycle watchdog for a partially assembled word
//
// Purpose: counts cycles while run is high and no clear arrives; flags
// expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset
//   run        - counting enabled (partial word outstanding)
//   clear      - restart count (byte accepted); wins over expiry
//   expired    - combinational; the current edge is the TIMEOUT_CYCLES-th idle edge
// Only instantiated when USB_ASSEMBLER_TIMEOUT_EN is defined.

module usb_cfg_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the number of idle edges already seen; the edge on which it
  // equals LAST_CNT is the expiry edge.
  assign expired = run && !clear && (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (clear || !run || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/usb_bitstream_word_assembler.sv
// rtl/usb_bitstream_word_assembler.sv - hunts for sync and packs USB bytes into 32-bit config words
//
// Purpose: receives the FPGA bitstream byte by byte from the USB CDC endpoint,
// locates the byte-aligned sync word, then packs each following group of four
// bytes (MSB first) into a configuration word issued on a one-cycle strobe.
// Ports:
//   clk_i               - clock, rising edge
//   reset_n_i           - asynchronous active-low reset
//   in_data_i[7:0]      - byte from USB core
//   in_valid_i          - in_data_i valid
//   in_ready_o          - byte can be accepted (0 in reset, 1 afterwards)
//   write_data_o[31:0]  - last assembled word
//   word_write_strobe_o - one-cycle pulse, write_data_o valid
//   synced_o            - high while synced
//   timeout_o           - one-cycle pulse when a partial word is dropped
//   word_count_o[15:0]  - words strobed since reset, wrapping
// Optional feature: define USB_ASSEMBLER_TIMEOUT_EN to drop partial words
// after TIMEOUT_CYCLES idle cycles; otherwise timeout_o is tied 0.

module usb_bitstream_word_assembler
  import usb_cfg_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter logic [31:0] DESYNC_WORD    = DESYNC_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] write_data_o,
  output logic        word_write_strobe_o,
  output logic        synced_o,
  output logic        timeout_o,
  output logic [15:0] word_count_o
);

  asm_state_e            state_q, state_d;
  logic                  ready_q;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           pack_q, pack_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]           data_q, data_d;
  logic                  strobe_q, strobe_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           count_q, count_d;

  logic                  accept;
  logic [31:0]           shift_in;
  logic [31:0]           pack_next;
  logic                  expired;

  assign accept    = in_valid_i && ready_q;
  assign shift_in  = {shift_q[23:0], in_data_i};
  assign pack_next = put_byte_msb_first(pack_q, idx_q, in_data_i);

`ifdef USB_ASSEMBLER_TIMEOUT_EN
  usb_cfg_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .run      ((state_q == ST_SYNCED) && (idx_q != '0)),
    .clear    (accept),
    .expired  (expired)
  );
`else
  // No watchdog: a partial word waits indefinitely. The expression is
  // constant 0 for any legal TIMEOUT_CYCLES.
  assign expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pack_d    = pack_q;
    idx_d     = idx_q;
    data_d    = data_q;
    count_d   = count_q;
    strobe_d  = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (accept) begin
          shift_d = shift_in;
          if (shift_in == SYNC_WORD) begin
            state_d = ST_SYNCED;
            idx_d   = '0;
          end
        end
      end

      ST_SYNCED: begin
        if (accept) begin
          pack_d = pack_next;
          idx_d  = idx_q + BYTE_IDX_W'(1);
          if (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
            if (pack_next == DESYNC_WORD) begin
              state_d = ST_HUNT;
              shift_d = '0;
            end else if (pack_next != SYNC_WORD) begin
              // A repeated sync word is swallowed; anything else is data.
              data_d   = pack_next;
              strobe_d = 1'b1;
              count_d  = count_q + 16'd1;
            end
          end
        end else if (expired) begin
          state_d   = ST_HUNT;
          idx_d     = '0;
          shift_d   = '0;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_HUNT;
      ready_q   <= 1'b0;
      shift_q   <= '0;
      pack_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      shift_q   <= shift_d;
      pack_q    <= pack_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign in_ready_o          = ready_q;
  assign write_data_o        = data_q;
  assign word_write_strobe_o = strobe_q;
  assign synced_o            = (state_q == ST_SYNCED);
  assign timeout_o           = timeout_q;
  assign word_count_o        = count_q;

endmodule

// File: tb/tb_usb_bitstream_word_assembler.sv
// tb/tb_usb_bitstream_word_assembler.sv - directed self-checking bench for usb_bitstream_word_assembler

module tb_usb_bitstream_word_assembler;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] write_data_o;
  logic        word_write_strobe_o;
  logic        synced_o;
  logic        timeout_o;
  logic [15:0] word_count_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          timeouts = 0;
  logic [31:0] words[$];
  int          times[$];
  int          base;
  int          t0;

  always #5 clk_i = ~clk_i;

  usb_bitstream_word_assembler #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .in_data_i          (in_data_i),
    .in_valid_i         (in_valid_i),
    .in_ready_o         (in_ready_o),
    .write_data_o       (write_data_o),
    .word_write_strobe_o(word_write_strobe_o),
    .synced_o           (synced_o),
    .timeout_o          (timeout_o),
    .word_count_o       (word_count_o)
  );

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (word_write_strobe_o === 1'b1) begin
      words.push_back(write_data_o);
      times.push_back(cyc);
    end
    if (timeout_o === 1'b1) timeouts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid_i = 1'b1;
    in_data_i  = b;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i  = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;

    // Reset state
    idle(3);
    check("rst_ready", 32'(in_ready_o), 32'd0);
    check("rst_data", write_data_o, 32'd0);
    check("rst_strobe", 32'(word_write_strobe_o), 32'd0);
    check("rst_synced", 32'(synced_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_count", 32'(word_count_o), 32'd0);
    reset_n_i = 1'b1;
    idle(1);
    check("ready_after_rst", 32'(in_ready_o), 32'd1);

    // Preamble, sync, two back-to-back words
    repeat (16) send(8'hFF);
    send(8'hFA); send(8'hB0); send(8'hFA);
    check("synced_before_b1", 32'(synced_o), 32'd0);
    send(8'hB1);
    check("synced_after_b1", 32'(synced_o), 32'd1);
    base = words.size();
    send_word(32'h0123_4567);
    send_word(32'h89AB_CDEF);
    idle(1);
    check("t1_nstrobes", 32'(words.size() - base), 32'd2);
    check("t1_word0", words[base], 32'h0123_4567);
    check("t1_word1", words[base+1], 32'h89AB_CDEF);
    check("t1_spacing", 32'(times[base+1] - times[base]), 32'd4);
    check("t1_count", 32'(word_count_o), 32'd2);
    check("t1_data_hold", write_data_o, 32'h89AB_CDEF);

    // Desync word returns to hunt; following data is ignored
    base = words.size();
    send_word(32'h1122_3344);
    send_word(32'h0000_0008);
    check("t3_synced_fall", 32'(synced_o), 32'd0);
    send_word(32'h5566_7788);
    idle(2);
    check("t3_nstrobes", 32'(words.size() - base), 32'd1);
    check("t3_word0", words[base], 32'h1122_3344);
    check("t3_count", 32'(word_count_o), 32'd3);
    check("t3_synced", 32'(synced_o), 32'd0);

    // Misaligned sync
    base = words.size();
    send(8'h00); send(8'hFA); send(8'hFA); send(8'hB0); send(8'hFA); send(8'hB1);
    check("t2_synced", 32'(synced_o), 32'd1);
    send_word(32'hDEAD_BEEF);
    idle(1);
    check("t2_nstrobes", 32'(words.size() - base), 32'd1);
    check("t2_word0", words[base], 32'hDEAD_BEEF);
    check("t2_count", 32'(word_count_o), 32'd4);

    // Three idle cycles between bytes
    base = words.size();
    send(8'h01); idle(3); send(8'h23); idle(3); send(8'h45); idle(3); send(8'h67); idle(3);
    send(8'h89); idle(3); send(8'hAB); idle(3); send(8'hCD); idle(3); send(8'hEF); idle(3);
    check("t4_nstrobes", 32'(words.size() - base), 32'd2);
    check("t4_word0", words[base], 32'h0123_4567);
    check("t4_word1", words[base+1], 32'h89AB_CDEF);
    check("t4_spacing", 32'(times[base+1] - times[base]), 32'd16);
    check("t4_count", 32'(word_count_o), 32'd6);

    // Partial word followed by idle time
    base = words.size();
    t0 = timeouts;
    send(8'hAA); send(8'hBB);
    idle(8);
`ifdef USB_ASSEMBLER_TIMEOUT_EN
    check("t5_timeout_pulse", 32'(timeout_o), 32'd1);
    check("t5_synced", 32'(synced_o), 32'd0);
    idle(1);
    check("t5_timeout_one_cycle", 32'(timeout_o), 32'd0);
    check("t5_ntimeouts", 32'(timeouts - t0), 32'd1);
    check("t5_nstrobes", 32'(words.size() - base), 32'd0);
    check("t5_count", 32'(word_count_o), 32'd6);
`else
    check("t5_ntimeouts", 32'(timeouts - t0), 32'd0);
    check("t5_synced", 32'(synced_o), 32'd1);
    send(8'hCC); send(8'hDD);
    idle(1);
    check("t5_nstrobes", 32'(words.size() - base), 32'd1);
    check("t5_word0", words[base], 32'hAABB_CCDD);
    check("t5_count", 32'(word_count_o), 32'd7);
`endif

    // Reset mid-word, then resend
    send(8'hFA); send(8'hB0); send(8'hFA); send(8'hB1);
    send(8'h11); send(8'h22);
    reset_n_i = 1'b0;
    #2;
    check("t6_rst_ready", 32'(in_ready_o), 32'd0);
    check("t6_rst_data", write_data_o, 32'd0);
    check("t6_rst_strobe", 32'(word_write_strobe_o), 32'd0);
    check("t6_rst_synced", 32'(synced_o), 32'd0);
    check("t6_rst_timeout", 32'(timeout_o), 32'd0);
    check("t6_rst_count", 32'(word_count_o), 32'd0);
    idle(2);
    reset_n_i = 1'b1;
    idle(1);
    check("t6_ready", 32'(in_ready_o), 32'd1);
    base = words.size();
    send(8'hFA); send(8'hB0); send(8'hFA); send(8'hB1);
    send_word(32'h0123_4567);
    idle(1);
    check("t6_nstrobes", 32'(words.size() - base), 32'd1);
    check("t6_word0", words[base], 32'h0123_4567);
    check("t6_count", 32'(word_count_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
